// File: rtl/seq_divider_8_pkg.sv
// Shared widths, counter sizing and FSM encodings for the sequential sign-magnitude divider.
// Imported by the divider interface, the step slice and the divider top.
package calc_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef logic [DIVIDEND_W-1:0] quo_t;
    typedef logic [DIVISOR_W-1:0]  dvs_t;
    typedef logic [DIVISOR_W:0]    prem_t;

    // Sign of a magnitude result: a zero magnitude is never reported as negative.
    function automatic logic result_sign(input logic sign, input logic nonzero);
        return sign & nonzero;
    endfunction

endpackage

// File: rtl/seq_divider_8_if.sv
// Start/done handshake and operand/result bus between the operation controller and the divider.
// The controller drives operands and start; the divider returns the results and status.
interface seq_divider_8_if;
    import calc_div_pkg::*;

    logic  start;
    quo_t  dividend;
    dvs_t  divisor;
    logic  Asign;
    logic  Bsign;
    quo_t  quotient;
    dvs_t  remainder;
    logic  negative;
    logic  rem_negative;
    logic  busy;
    logic  done;
    logic  div_by_zero;

    modport master (
        output start, dividend, divisor, Asign, Bsign,
        input  quotient, remainder, negative, rem_negative, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, Asign, Bsign,
        output quotient, remainder, negative, rem_negative, busy, done, div_by_zero
    );

endinterface

// File: rtl/seq_divider_8_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
// Purely combinational; no handshake.
module div_step
    import calc_div_pkg::*;
(
    input  prem_t rem_i,
    input  logic  bit_i,
    input  dvs_t  divisor_i,
    output prem_t rem_o,
    output logic  q_o
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    assign shifted = {rem_i, bit_i};
    // Extra top bit acts as the borrow flag of the trial subtraction.
    assign diff    = shifted - {2'b00, divisor_i};
    assign q_o     = ~diff[DIVISOR_W+1];
    assign rem_o   = q_o ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider_8.sv
// Sequential restoring divider, one quotient bit per clock: done 17 cycles after start, 1 on divide-by-zero.
// start is only honoured in IDLE; requests while busy or in DONE are dropped, never queued.
module seq_divider_8
    import calc_div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    seq_divider_8_if.slave       bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    quo_t              dvd_q, dvd_d;
    dvs_t              dvs_q, dvs_d;
    prem_t             rem_q, rem_d;
    quo_t              quo_q, quo_d;
    logic              asign_q, asign_d;
    logic              bsign_q, bsign_d;

    quo_t              quotient_q, quotient_d;
    dvs_t              remainder_q, remainder_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    prem_t             step_rem;
    logic              step_q;
    quo_t              quo_next;

    div_step u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quo_next = {quo_q[DIVIDEND_W-2:0], step_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        asign_d     = asign_q;
        bsign_d     = bsign_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        neg_d       = neg_q;
        rem_neg_d   = rem_neg_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    asign_d = bus.Asign;
                    bsign_d = bus.Bsign;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(DIVIDEND_W);
                    dbz_d   = 1'b0;
                    if (bus.divisor == '0) begin
                        // Zero divisor skips the iteration and posts the saturated result.
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                        neg_d       = 1'b0;
                        rem_neg_d   = 1'b0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                quo_d = quo_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    quotient_d  = quo_next;
                    remainder_d = step_rem[DIVISOR_W-1:0];
                    neg_d       = result_sign(asign_q ^ bsign_q, |quo_next);
                    rem_neg_d   = result_sign(asign_q, |step_rem[DIVISOR_W-1:0]);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            asign_q     <= 1'b0;
            bsign_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            asign_q     <= asign_d;
            bsign_q     <= bsign_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.quotient     = quotient_q;
    assign bus.remainder    = remainder_q;
    assign bus.negative     = neg_q;
    assign bus.rem_negative = rem_neg_q;
    assign bus.busy         = (state_q == ST_RUN);
    assign bus.done         = done_q;
    assign bus.div_by_zero  = dbz_q;

endmodule

// File: tb/tb_seq_divider_8.sv
// Directed bench for seq_divider_8: stimulus pushes hand-computed results, a done-driven monitor checks them.
module tb_seq_divider_8;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        n;
        logic        rn;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon_e;

    seq_divider_8_if dif();

    seq_divider_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] q, input logic [7:0] r,
                                input logic n, input logic rn, input logic dz);
        exp_t e;
        e.q = q; e.r = r; e.n = n; e.rn = rn; e.dz = dz;
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && dif.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient",     32'(dif.quotient),     32'(mon_e.q));
                chk("remainder",    32'(dif.remainder),    32'(mon_e.r));
                chk("negative",     32'(dif.negative),     32'(mon_e.n));
                chk("rem_negative", 32'(dif.rem_negative), 32'(mon_e.rn));
                chk("div_by_zero",  32'(dif.div_by_zero),  32'(mon_e.dz));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_quotient"},     32'(dif.quotient),     32'd0);
        chk({tag, "_remainder"},    32'(dif.remainder),    32'd0);
        chk({tag, "_negative"},     32'(dif.negative),     32'd0);
        chk({tag, "_rem_negative"}, 32'(dif.rem_negative), 32'd0);
        chk({tag, "_busy"},         32'(dif.busy),         32'd0);
        chk({tag, "_done"},         32'(dif.done),         32'd0);
        chk({tag, "_div_by_zero"},  32'(dif.div_by_zero),  32'd0);
    endtask

    // Issue one division at a negedge in IDLE; returns at the negedge of the IDLE cycle after done.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b, input logic as_i, input logic bs_i,
                           input exp_t e, input int repulse, input string tag);
        int   lat;
        int   done_cyc;
        logic busy_ok;
        lat = (b == 8'd0) ? 1 : 17;
        sb.push_back(e);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        dif.Asign    = as_i;
        dif.Bsign    = bs_i;
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.dividend = 16'($urandom);
        dif.divisor  = 8'($urandom);
        dif.Asign    = 1'($urandom);
        dif.Bsign    = 1'($urandom);
        done_cyc = 0;
        busy_ok  = 1'b1;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (dif.busy !== (c < lat)) busy_ok = 1'b0;
            if (dif.done === 1'b1) done_cyc = c;
            if (c == 1 && b != 8'd0) chk({tag, "_dbz_cleared"}, 32'(dif.div_by_zero), 32'd0);
            if (c == repulse) begin
                dif.start    = 1'b1;
                dif.dividend = 16'd50;
                dif.divisor  = 8'd5;
            end else begin
                dif.start = 1'b0;
            end
        end
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(lat));
        chk({tag, "_busy_window"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int d1;
        int d2;
        int dones;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        dif.Asign    = 1'b0;
        dif.Bsign    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        run_div(16'd1000,  8'd7, 1'b0, 1'b0, mk(16'd142,   8'd6, 1'b0, 1'b0, 1'b0), 0, "d1000_7");
        run_div(16'd100,   8'd3, 1'b1, 1'b0, mk(16'd33,    8'd1, 1'b1, 1'b1, 1'b0), 0, "d100_3n");
        run_div(16'd65535, 8'd1, 1'b0, 1'b0, mk(16'd65535, 8'd0, 1'b0, 1'b0, 1'b0), 0, "d65535_1");
        run_div(16'd0,     8'd5, 1'b1, 1'b0, mk(16'd0,     8'd0, 1'b0, 1'b0, 1'b0), 0, "d0_5n");
        run_div(16'd255,   8'd0, 1'b0, 1'b0, mk(16'hFFFF,  8'd0, 1'b0, 1'b0, 1'b1), 0, "d255_0");
        run_div(16'd9,     8'd2, 1'b0, 1'b1, mk(16'd4,     8'd1, 1'b1, 1'b0, 1'b0), 0, "d9_2_after_dbz");
        run_div(16'd1000,  8'd7, 1'b0, 1'b0, mk(16'd142,   8'd6, 1'b0, 1'b0, 1'b0), 5, "repulse");

        // start held high: second operands are picked up in the IDLE cycle after done.
        sb.push_back(mk(16'd142, 8'd6, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(16'd22,  8'd2, 1'b1, 1'b0, 1'b0));
        dif.start    = 1'b1;
        dif.dividend = 16'd1000;
        dif.divisor  = 8'd7;
        dif.Asign    = 1'b0;
        dif.Bsign    = 1'b0;
        @(posedge clk);
        #1;
        dif.dividend = 16'd200;
        dif.divisor  = 8'd9;
        dif.Bsign    = 1'b1;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 60 && d2 == 0; c++) begin
            @(negedge clk);
            if (dif.done === 1'b1) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
            if (c == 19) dif.start = 1'b0;
        end
        chk("held_first_done", 32'(d1), 32'd17);
        chk("held_second_done", 32'(d2), 32'd35);
        @(negedge clk);

        // Reset in the middle of a division discards it.
        dif.start    = 1'b1;
        dif.dividend = 16'd1000;
        dif.divisor  = 8'd7;
        dif.Asign    = 1'b1;
        dif.Bsign    = 1'b0;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 8) rst = 1'b1;
        end
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (dif.done === 1'b1) dones++;
        end
        chk("no_done_after_reset", 32'(dones), 32'd0);

        run_div(16'd9, 8'd2, 1'b0, 1'b0, mk(16'd4, 8'd1, 1'b0, 1'b0, 1'b0), 0, "d9_2_after_reset");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_divider_8.md
Name: seq_divider_8

Overview:
Sequential sign-magnitude restoring divider. It is the inverse companion to the calculator's 8x8 combinational multiplier. It divides a 16-bit magnitude dividend by an 8-bit magnitude divisor, one quotient bit per clock, and returns a 16-bit quotient and an 8-bit remainder. Signs travel separately, as in the multiplier path. It sits in the calculator datapath beside the multiplier and is driven by the operation controller through a start/done handshake.

Parameters:
DIVIDEND_W, 16, dividend and quotient width
DIVISOR_W, 8, divisor and remainder width

Ports:
clk  input  1  system clock
rst  input  1  reset: one clock; reset is synchronous and active-high
start  input  1  request; sampled only in IDLE
dividend  input  DIVIDEND_W  dividend magnitude
divisor  input  DIVISOR_W  divisor magnitude
Asign  input  1  dividend sign (1 = negative)
Bsign  input  1  divisor sign (1 = negative)
quotient  output  DIVIDEND_W  quotient magnitude
remainder  output  DIVISOR_W  remainder magnitude
negative  output  1  quotient sign
rem_negative  output  1  remainder sign
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when results become valid
div_by_zero  output  1  divisor was zero; held with the results

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Internal registers are cleared.
  - Reset overrides every other input, including mid-operation; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch dividend, divisor, Asign and Bsign.
  - Clear the partial remainder (DIVISOR_W+1 bits) and load the counter with DIVIDEND_W.
  - If divisor != 0, go to RUN and set busy=1.
  - If divisor == 0, go directly to DONE.
- RUN, each cycle:
  - Shift the partial remainder left by 1, bringing in the dividend MSB.
  - Shift the dividend register left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and shift 1 into the quotient; otherwise keep the shifted value and shift 0 in.
  - Decrement the counter. After the DIVIDEND_W-th step, go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - Result outputs are registered on entry to DONE and hold until the next accepted start or reset.
  - Next state is IDLE.
- Latency: start sampled at edge 0, done high in cycle DIVIDEND_W+1 (17 by default). Divide-by-zero: done high in cycle 1.
- Result rules:
  - negative = Asign ^ Bsign, forced to 0 when quotient == 0.
  - rem_negative = Asign, forced to 0 when remainder == 0 (truncating division).
  - Divide-by-zero: quotient = all ones, remainder = 0, negative = 0, rem_negative = 0, div_by_zero = 1.
  - div_by_zero clears on the next accepted start.
- start while busy or in DONE is ignored; no queuing.
- start held high continuously: a new division is accepted at each IDLE visit, i.e. back-to-back every DIVIDEND_W+2 cycles.
- Input buses may change freely after the start cycle without affecting the result.
- Quotient cannot overflow (DIVIDEND_W bits always suffice). The remainder is always less than the divisor.

Decomposition:
- Shared package calc_div_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default widths;
  - the counter width, defined as clog2(DIVIDEND_W+1).
- One combinational sub-module, div_step:
  - inputs: partial remainder, incoming bit, divisor;
  - outputs: next partial remainder and quotient bit.
- The FSM, counter and registers stay in seq_divider_8.

Test Plan:
- dividend=1000, divisor=7, signs 0/0, one-cycle start -> done at cycle 17; quotient=142, remainder=6, negative=0, rem_negative=0, div_by_zero=0; busy high in cycles 1-16.
- dividend=100, Asign=1, divisor=3, Bsign=0 -> quotient=33, negative=1, remainder=1, rem_negative=1.
- dividend=65535, divisor=1 -> quotient=65535, remainder=0. Then dividend=0, divisor=5, Asign=1 -> quotient=0, negative=0, rem_negative=0.
- dividend=255, divisor=0 -> done at cycle 1; quotient=16'hFFFF, remainder=0, div_by_zero=1. A following valid start clears div_by_zero.
- Start 1000/7, re-pulse start with 50/5 at cycle 5 -> ignored; result is 142 r 6. Start held high over two runs -> second division accepted in the IDLE cycle after done.
- Start 1000/7, assert rst at cycle 8 -> all outputs 0 next cycle, busy=0, no done pulse. A new start 9/2 -> quotient=4, remainder=1.
